// File: rtl/imem_access_arbiter.sv
// Round-robin arbiter between a read-only fetch port and a read/write loader port
// in front of one single-port synchronous instruction RAM, one transaction in flight.
module imem_access_arbiter #(
  parameter int          DEPTH     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  localparam int         AW        = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          f_req_valid_i,
  output logic          f_req_ready_o,
  input  logic [31:0]   f_addr_i,
  output logic          f_resp_valid_o,
  input  logic          f_resp_ready_i,
  output logic [31:0]   f_rdata_o,
  output logic          f_err_o,
  input  logic          l_req_valid_i,
  output logic          l_req_ready_o,
  input  logic [31:0]   l_addr_i,
  input  logic          l_we_i,
  input  logic [31:0]   l_wdata_i,
  output logic          l_resp_valid_o,
  input  logic          l_resp_ready_i,
  output logic [31:0]   l_rdata_o,
  output logic          l_err_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i,
  output logic          busy_o
);

  localparam logic [31:0] LIMIT = 32'(4 * DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  logic        owner_l;     // 1: loader owns the transaction in flight
  logic        last_l;      // 1: loader was granted most recently
  logic        resp_we;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        accept;
  logic        grant_l;
  logic [31:0] sel_addr;
  logic [31:0] off;
  logic        fault;

  always_comb begin
    accept  = 1'b0;
    grant_l = 1'b0;
    if (state == IDLE && !rst_i && (f_req_valid_i || l_req_valid_i)) begin
      accept  = 1'b1;
      // On contention the loader wins only if fetch was served last.
      grant_l = l_req_valid_i && (!f_req_valid_i || !last_l);
    end
    sel_addr = grant_l ? l_addr_i : f_addr_i;
    off      = sel_addr - BASE_ADDR;
    fault    = (off[1:0] != 2'b00) || (off >= LIMIT);
  end

  assign f_req_ready_o = accept && !grant_l;
  assign l_req_ready_o = accept && grant_l;
  assign mem_en_o      = accept && !fault;
  assign mem_we_o      = mem_en_o && grant_l && l_we_i;
  assign mem_addr_o    = off[AW+1:2];
  assign mem_wdata_o   = l_wdata_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      owner_l    <= 1'b0;
      last_l     <= 1'b1;
      resp_we    <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner_l <= grant_l;
            last_l  <= grant_l;
            resp_we <= grant_l && l_we_i;
            if (fault) begin
              resp_rdata <= 32'h0;
              resp_err   <= 1'b1;
              state      <= RESP;
            end else begin
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          resp_rdata <= resp_we ? 32'h0 : mem_rdata_i;
          resp_err   <= 1'b0;
          state      <= RESP;
        end
        RESP: begin
          if (owner_l ? l_resp_ready_i : f_resp_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o         = (state != IDLE);
  assign f_resp_valid_o = (state == RESP) && !owner_l;
  assign l_resp_valid_o = (state == RESP) && owner_l;
  assign f_rdata_o      = f_resp_valid_o ? resp_rdata : 32'h0;
  assign l_rdata_o      = l_resp_valid_o ? resp_rdata : 32'h0;
  assign f_err_o        = f_resp_valid_o && resp_err;
  assign l_err_o        = l_resp_valid_o && resp_err;

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Scoreboard bench for imem_access_arbiter: expectations pushed at accept, checked at response.
module tb_imem_access_arbiter;
  localparam int          DEPTH = 16;
  localparam int          AW    = $clog2(DEPTH);
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst;
  logic f_req_valid, f_req_ready, f_resp_valid, f_resp_ready, f_err;
  logic [31:0] f_addr, f_rdata;
  logic l_req_valid, l_req_ready, l_we, l_resp_valid, l_resp_ready, l_err;
  logic [31:0] l_addr, l_wdata, l_rdata;
  logic mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  imem_access_arbiter #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk_i(clk), .rst_i(rst),
    .f_req_valid_i(f_req_valid), .f_req_ready_o(f_req_ready), .f_addr_i(f_addr),
    .f_resp_valid_o(f_resp_valid), .f_resp_ready_i(f_resp_ready),
    .f_rdata_o(f_rdata), .f_err_o(f_err),
    .l_req_valid_i(l_req_valid), .l_req_ready_o(l_req_ready), .l_addr_i(l_addr),
    .l_we_i(l_we), .l_wdata_i(l_wdata),
    .l_resp_valid_o(l_resp_valid), .l_resp_ready_i(l_resp_ready),
    .l_rdata_o(l_rdata), .l_err_o(l_err),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered-read RAM
  logic [31:0] ram [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = i * 32'h0101_0101 + 32'h100;
    ram[1] = 32'h00A0_0093;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  typedef struct {
    bit          port;
    logic [31:0] rdata;
    bit          err;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  bit   gq[$];
  int   gc[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  logic [31:0] shadow [DEPTH];

  task automatic on_accept(input bit port, input logic [31:0] addr, input bit we,
                           input logic [31:0] wd);
    logic [31:0] off;
    logic [AW-1:0] idx;
    bit flt;
    exp_t e;
    off = addr - BASE;
    flt = (off[1:0] != 2'b00) || (off >= 32'(4 * DEPTH));
    idx = off[AW+1:2];
    chk("mem_en", mem_en, !flt);
    if (!flt) begin
      chk("mem_addr", mem_addr, idx);
      chk("mem_we", mem_we, port && we);
      if (port && we) chk("mem_wdata", mem_wdata, wd);
    end
    e.port  = port;
    e.err   = flt;
    e.rdata = (flt || (port && we)) ? 32'h0 : shadow[idx];
    e.acc   = cyc;
    e.lat   = flt ? 1 : 2;
    if (!flt && port && we) shadow[idx] = wd;
    sb.push_back(e);
    gq.push_back(port);
    gc.push_back(cyc);
  endtask

  // Accept and response monitor, sampled on the falling edge
  initial begin
    logic [1:0] rv, rr, pv, prev_v;
    logic [31:0] rd [2];
    logic [31:0] pd [2];
    logic [1:0] er, pe;
    exp_t e;
    for (int i = 0; i < DEPTH; i++) shadow[i] = i * 32'h0101_0101 + 32'h100;
    shadow[1] = 32'h00A0_0093;
    pv = '0; prev_v = '0; pe = '0;
    pd[0] = '0; pd[1] = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        pv = '0;
        prev_v = '0;
      end else begin
        if (f_req_valid && l_req_valid) chk("one_ready", f_req_ready & l_req_ready, 0);
        if (f_req_valid && f_req_ready) on_accept(1'b0, f_addr, 1'b0, 32'h0);
        if (l_req_valid && l_req_ready) on_accept(1'b1, l_addr, l_we, l_wdata);
        rv = {l_resp_valid, f_resp_valid};
        rr = {l_resp_ready, f_resp_ready};
        rd[0] = f_rdata; rd[1] = l_rdata;
        er = {l_err, f_err};
        if (rv != 2'b00) chk("resp_excl", rv[0] & rv[1], 0);
        for (int p = 0; p < 2; p++) begin
          if (pv[p]) begin
            chk("hold_valid", rv[p], 1);
            chk("hold_rdata", rd[p], pd[p]);
            chk("hold_err", er[p], pe[p]);
          end
          if (rv[p] && !prev_v[p]) begin
            if (sb.size() == 0) chk("unexpected_valid", 1, 0);
            else chk("latency", cyc - sb[0].acc, sb[0].lat);
          end
          if (rv[p] && rr[p]) begin
            if (sb.size() == 0) chk("unexpected_resp", 1, 0);
            else begin
              e = sb.pop_front();
              chk("resp_port", p, e.port);
              chk("resp_rdata", rd[p], e.rdata);
              chk("resp_err", er[p], e.err);
            end
          end
          pv[p] = rv[p] && !rr[p];
          pd[p] = rd[p];
          pe[p] = er[p];
          prev_v[p] = rv[p];
        end
      end
    end
  end

  task automatic wait_done();
    int t = 0;
    while ((sb.size() != 0 || busy) && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("done_timeout", t < 50, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    f_req_valid = 1'b0;
    l_req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic f_rd(input logic [31:0] addr);
    int t = 0;
    @(posedge clk); #1;
    f_req_valid = 1'b1;
    f_addr = addr;
    do begin @(negedge clk); t++; end while (!f_req_ready && t < 20);
    chk("f_accept_timeout", f_req_ready, 1);
    @(posedge clk); #1 f_req_valid = 1'b0;
    wait_done();
  endtask

  task automatic l_op(input logic [31:0] addr, input bit we, input logic [31:0] wd);
    int t = 0;
    @(posedge clk); #1;
    l_req_valid = 1'b1;
    l_addr = addr;
    l_we = we;
    l_wdata = wd;
    do begin @(negedge clk); t++; end while (!l_req_ready && t < 20);
    chk("l_accept_timeout", l_req_ready, 1);
    @(posedge clk); #1 l_req_valid = 1'b0;
    wait_done();
  endtask

  // Both requesters held valid; grants must alternate starting with fetch
  task automatic contend(input int n);
    int t = 0;
    gq.delete();
    gc.delete();
    @(posedge clk); #1;
    f_req_valid = 1'b1; f_addr = BASE + 32'h4;
    l_req_valid = 1'b1; l_addr = BASE + 32'hC; l_we = 1'b0;
    while (gq.size() < n && t < 40) begin @(negedge clk); t++; end
    chk("contend_timeout", t < 40, 1);
    @(posedge clk); #1;
    f_req_valid = 1'b0;
    l_req_valid = 1'b0;
    wait_done();
    for (int i = 0; i < n && i < gq.size(); i++) begin
      chk("grant_order", gq[i], i % 2);
      if (i > 0) chk("cadence", gc[i] - gc[i-1], 3);
    end
  endtask

  initial begin
    int t;
    rst = 1'b1;
    f_req_valid = 1'b0; f_addr = '0; f_resp_ready = 1'b0;
    l_req_valid = 1'b0; l_addr = '0; l_we = 1'b0; l_wdata = '0; l_resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_f_valid", f_resp_valid, 0);
    chk("rst_l_valid", l_resp_valid, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_f_rdata", f_rdata, 0);
    chk("rst_l_rdata", l_rdata, 0);
    chk("rst_f_err", f_err, 0);
    chk("rst_l_err", l_err, 0);
    f_resp_ready = 1'b1;
    l_resp_ready = 1'b1;

    f_rd(BASE + 32'h4);
    l_op(BASE + 32'h8, 1'b1, 32'hDEAD_BEEF);
    f_rd(BASE + 32'h8);
    l_op(BASE + 32'h3C, 1'b1, 32'h1234_5678);
    l_op(BASE + 32'h3C, 1'b0, 32'h0);
    f_rd(BASE + 32'h0);

    f_rd(BASE + 32'h40);
    f_rd(BASE + 32'h2);
    f_rd(32'h7FFF_FFFC);
    l_op(BASE + 32'h44, 1'b1, 32'hBAD0_BAD0);
    l_op(BASE + 32'h41, 1'b0, 32'h0);

    do_reset();
    contend(4);

    // Response backpressure with a loader request waiting
    f_resp_ready = 1'b0;
    @(posedge clk); #1;
    f_req_valid = 1'b1; f_addr = BASE + 32'h4;
    t = 0;
    do begin @(negedge clk); t++; end while (!f_req_ready && t < 20);
    chk("bp_accept", f_req_ready, 1);
    @(posedge clk); #1;
    f_req_valid = 1'b0;
    l_req_valid = 1'b1; l_addr = BASE + 32'h8; l_we = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!f_resp_valid && t < 20);
    chk("bp_resp_timeout", f_resp_valid, 1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_busy", busy, 1);
      chk("bp_l_ready", l_req_ready, 0);
      chk("bp_f_valid", f_resp_valid, 1);
    end
    @(posedge clk); #1 f_resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_l_ready", l_req_ready, 1);
    chk("bp_release_busy", busy, 0);
    @(posedge clk); #1 l_req_valid = 1'b0;
    wait_done();

    // Reset while a loader read sits in ACCESS
    @(posedge clk); #1;
    l_req_valid = 1'b1; l_addr = BASE + 32'h10; l_we = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!l_req_ready && t < 20);
    chk("rst6_accept", l_req_ready, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    l_req_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst6_busy", busy, 0);
    chk("rst6_l_valid", l_resp_valid, 0);
    chk("rst6_f_valid", f_resp_valid, 0);
    chk("rst6_mem_en", mem_en, 0);
    chk("rst6_f_ready", f_req_ready, 0);
    chk("rst6_l_ready", l_req_ready, 0);
    repeat (4) begin
      @(negedge clk);
      chk("rst6_no_resp", l_resp_valid, 0);
    end
    contend(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imem_access_arbiter.md
Name: imem_access_arbiter

Overview:
- Sits between two requesters and one single-port synchronous instruction RAM.
- The core fetch port is read-only; the loader/debug port can read and write.
- Translates byte addresses in the BASE_ADDR window to word indices and range/alignment-checks every request.
- Arbitrates round-robin with one transaction outstanding and returns each response on a valid/ready channel.

Parameters:
- DEPTH, 16: RAM depth in 32-bit words. Must be a power of 2 and at least 2.
- BASE_ADDR, 32'h8000_0000: byte address of word 0. Must be 4-byte aligned.
- AW, $clog2(DEPTH): localparam, RAM index width.

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_i  in  1  synchronous, active-high reset
f_req_valid_i  in  1  fetch request valid
f_req_ready_o  out  1  fetch request accepted this cycle
f_addr_i  in  32  fetch byte address
f_resp_valid_o  out  1  fetch response valid
f_resp_ready_i  in  1  fetch response consumed
f_rdata_o  out  32  fetch read data
f_err_o  out  1  fetch access fault
l_req_valid_i  in  1  loader request valid
l_req_ready_o  out  1  loader request accepted
l_addr_i  in  32  loader byte address
l_we_i  in  1  1=write, 0=read
l_wdata_i  in  32  loader write data
l_resp_valid_o  out  1  loader response valid
l_resp_ready_i  in  1  loader response consumed
l_rdata_o  out  32  loader read data (0 for writes)
l_err_o  out  1  loader access fault
mem_en_o  out  1  RAM access strobe
mem_we_o  out  1  RAM write enable
mem_addr_o  out  AW  RAM word index
mem_wdata_o  out  32  RAM write data
mem_rdata_i  in  32  RAM read data, registered, valid the cycle after mem_en_o
busy_o  out  1  state != IDLE

Behaviour:
- Reset (sync, rst_i high at edge):
  - state=IDLE; rr pointer favours fetch.
  - Every *_valid_o, *_err_o, mem_en_o and mem_we_o is 0; every rdata output is 0.
  - Any in-flight response is discarded.
  - Reset overrides all other inputs.
- FSM states: IDLE -> (ACCESS | RESP); ACCESS -> RESP; RESP -> IDLE.
- IDLE, grant selection:
  - Grant is combinational. If only one requester is valid, it wins.
  - If both are valid, the winner is the one not granted last.
  - The winner's req_ready_o=1 in the same cycle; the other's is 0. ready may depend on valid.
  - The accept edge is when valid&ready is sampled. The requester is latched as owner and the rr pointer is updated.
- Address check, done on the accept cycle:
  - off = addr - BASE_ADDR, 32-bit unsigned wrap.
  - Fault if off[1:0]!=0 or off >= 4*DEPTH. Addresses below BASE wrap to a large off and fault.
- Legal request:
  - In the accept cycle: mem_en_o=1, mem_addr_o=off[AW+1:2].
  - mem_we_o=l_we_i only when the loader is granted, else 0.
  - mem_wdata_o=l_wdata_i.
  - Next state ACCESS.
- Faulting request: no mem_en_o; next state RESP with err=1, rdata=0.
- ACCESS:
  - Capture mem_rdata_i into the response register for reads, or 0 for writes; err=0.
  - Next state RESP. mem_en_o=0.
- RESP:
  - The owner's resp_valid_o=1; the other requester's resp_valid_o=0.
  - rdata/err are held stable until the owner's resp_ready_i=1 is sampled.
  - Then IDLE. No new request is accepted in the same cycle.
- Latency:
  - Legal request: resp_valid rises 2 cycles after accept.
  - Fault: resp_valid rises 1 cycle after accept.
  - Minimum cadence is one transaction per 3 cycles (2 for a fault).
- Outside IDLE: both req_ready_o=0. A requester keeps valid and its payload stable until accepted.
- rr pointer changes only on accept; a non-contended grant still updates it.
- busy_o=1 in ACCESS and RESP.

Test Plan:
1. Reset, preload RAM[1]=0x00A00093; fetch reads 0x8000_0004 -> f_req_ready=1 on that cycle, mem_en=1, mem_addr=1, mem_we=0; f_resp_valid=1 two cycles later with f_rdata=0x00A00093, f_err=0.
2. Loader writes 0x8000_0008 data 0xDEADBEEF -> mem_we=1, mem_addr=2, mem_wdata=0xDEADBEEF; l_resp with l_rdata=0, l_err=0. Then fetch reads 0x8000_0008 -> f_rdata=0xDEADBEEF.
3. Both requesters valid continuously after reset, resp_ready held 1 -> grant order F,L,F,L; each transaction takes 3 cycles; the non-owner's resp_valid stays 0.
4. Faults with DEPTH=16 at fetch addresses 0x8000_0040, 0x8000_0002 and 0x7FFF_FFFC -> no mem_en; f_resp_valid one cycle after accept with f_err=1, f_rdata=0.
5. Backpressure: hold f_resp_ready=0 for 5 cycles with a loader request pending -> f_rdata/f_err stable, busy_o=1, l_req_ready=0 throughout. Release -> IDLE next cycle, loader granted.
6. Assert rst_i during ACCESS of a loader read -> next cycle all valid/ready/mem_en are 0, no response is delivered, and a subsequent simultaneous request grants fetch first.
